// File: rtl/rf_buf_seq.sv
// rf_buf_seq: fills the RF sector buffer RAM from an upstream stream, then drains it in order downstream.
// Optional: define RF_BUF_CKSUM_EN for a ones-complement checksum of the filled words.
module rf_buf_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  input  logic              snk_ready,
  output logic [ADDR_W-1:0] buf_a,
  output logic [DATA_W-1:0] buf_din,
  input  logic [DATA_W-1:0] buf_dout,
  output logic              buf_ce,
  output logic              buf_we,
  output logic              busy,
  output logic              done
`ifdef RF_BUF_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum
`endif
);
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, RD = 3'd2, OUT = 3'd3, DONE = 3'd4;
  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt, r_len, w_cnt_nx;
  logic              w_fill, w_rd, w_out, w_wr, w_last;
  assign w_fill   = r_state == FILL;
  assign w_rd     = r_state == RD;
  assign w_out    = r_state == OUT;
  assign w_wr     = w_fill & src_valid & ~abort;
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_last   = w_cnt_nx == r_len;
  assign src_ready = w_fill & ~abort;
  assign snk_valid = w_out & ~abort;
  assign snk_data  = buf_dout;
  assign buf_a     = (w_fill | w_rd) ? r_ptr : '0;
  assign buf_din   = w_fill ? src_data : '0;
  assign buf_ce    = w_wr | w_rd;
  assign buf_we    = w_wr;
  assign busy      = r_state != IDLE;
  assign done      = r_state == DONE;
  // abort takes priority over every state transition, including a start in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= FILL;
          r_ptr   <= '0;
          r_cnt   <= '0;
          r_len   <= (len == '0) ? {1'b1, {ADDR_W{1'b0}}} : len;
        end
        FILL: if (src_valid) begin
          r_ptr   <= w_last ? '0 : r_ptr + 1'b1;
          r_cnt   <= w_last ? '0 : w_cnt_nx;
          r_state <= w_last ? RD : FILL;
        end
        RD: r_state <= OUT;
        OUT: if (snk_ready) begin
          r_ptr   <= r_ptr + 1'b1;
          r_cnt   <= w_cnt_nx;
          r_state <= w_last ? DONE : RD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef RF_BUF_CKSUM_EN
  logic [DATA_W-1:0] r_cksum;
  logic [DATA_W:0]   w_sum;
  assign w_sum = {1'b0, r_cksum} + {1'b0, src_data};
  assign cksum = r_cksum;
  // carry out of the top bit folds back into bit 0
  always_ff @(posedge clk) begin
    if (reset || (r_state == IDLE && start && !abort))
      r_cksum <= '0;
    else if (w_wr)
      r_cksum <= w_sum[DATA_W-1:0] + DATA_W'(w_sum[DATA_W]);
  end
`endif
endmodule

// File: tb/tb_rf_buf_seq.sv
// tb_rf_buf_seq: randomized self-checking bench for rf_buf_seq with a behavioural sync-read RAM.
module tb_rf_buf_seq;
  logic        clk = 0, reset = 1, start = 0, abort = 0, src_valid = 0, snk_ready = 0;
  logic [8:0]  len = '0;
  logic [11:0] src_data = '0, buf_dout = '0;
  logic        src_ready, snk_valid, buf_ce, buf_we, busy, done;
  logic [11:0] snk_data, buf_din;
  logic [7:0]  buf_a;
`ifdef RF_BUF_CKSUM_EN
  logic [11:0] cksum;
`endif
  logic [11:0] mem [256] = '{default: 12'hABC};
  logic [11:0] q [$];
  int total = 0, bad = 0;

  rf_buf_seq dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .buf_a(buf_a), .buf_din(buf_din), .buf_dout(buf_dout), .buf_ce(buf_ce), .buf_we(buf_we),
    .busy(busy), .done(done)
`ifdef RF_BUF_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (buf_ce) begin
    if (buf_we) mem[buf_a] <= buf_din;
    else buf_dout <= mem[buf_a];
  end

  task automatic xfer(input bit rnd, input int stall_idx, input bit poke);
    int n, idx, cyc, dones, st, ck;
    n = q.size(); idx = 0; dones = 0; st = 0; ck = 0;
    @(negedge clk); start = 1; len = (n == 256) ? 9'd0 : 9'(n);
    @(negedge clk); start = 0; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        src_valid = rnd ? 1'($urandom) : 1'b1; src_data = q[i]; #1;
        total++;
        if (src_ready !== 1'b1 || buf_ce !== src_valid || buf_we !== src_valid) begin
          bad++; $display("FAIL fill_ctl rdy=%b ce=%b we=%b exp 1,%b,%b", src_ready, buf_ce, buf_we, src_valid, src_valid);
        end
        if (src_valid) begin
          total++;
          if (buf_a !== 8'(i) || buf_din !== q[i]) begin
            bad++; $display("FAIL fill_addr a=%0d din=%o exp a=%0d din=%o", buf_a, buf_din, i % 256, q[i]);
          end
        end
        dones += int'(done);
        @(negedge clk); cyc++;
      end while (!src_valid && cyc < 30);
      if (!src_valid) begin total++; bad++; $display("FAIL fill_timeout word=%0d", i); end
      ck = ck + int'(q[i]); if (ck > 4095) ck -= 4095;
    end
    src_valid = 0; cyc = 0;
    while (idx < n && cyc < 5000) begin
      snk_ready = rnd ? 1'($urandom) : 1'b1;
      if (idx == stall_idx && st < 5) snk_ready = 0;
      start = (poke && cyc == 1); len = 9'd5;
      #1;
      dones += int'(done);
      if (snk_valid) begin
        total++;
        if (snk_data !== q[idx] || buf_ce !== 1'b0) begin
          bad++; $display("FAIL drain_data idx=%0d got=%o ce=%b exp=%o ce=0", idx, snk_data, buf_ce, q[idx]);
        end
        if (idx == stall_idx && !snk_ready) st++;
        if (snk_ready) idx++;
      end
      @(negedge clk); cyc++;
    end
    start = 0; snk_ready = 0;
    if (idx < n) begin total++; bad++; $display("FAIL drain_timeout got=%0d words exp=%0d", idx, n); end
    #1;
    total++; if (done !== 1'b1 || busy !== 1'b1 || dones !== 0) begin
      bad++; $display("FAIL done_pulse done=%b busy=%b early=%0d exp 1,1,0", done, busy, dones);
    end
`ifdef RF_BUF_CKSUM_EN
    total++; if (cksum !== 12'(ck)) begin bad++; $display("FAIL cksum got=%o exp=%o", cksum, 12'(ck)); end
`endif
    @(negedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_end done=%b busy=%b exp 0,0", done, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1; repeat (2) @(negedge clk); reset = 0; #1;
    total++;
    if ({src_ready, snk_valid, buf_ce, buf_we, busy, done} !== 6'b0 || buf_a !== 8'd0 || buf_din !== 12'd0) begin
      bad++; $display("FAIL reset_state ctl=%b a=%0d din=%o exp all 0", {src_ready, snk_valid, buf_ce, buf_we, busy, done}, buf_a, buf_din);
    end
  endtask

  task automatic test_basic;
    q = '{12'o1111, 12'o2222, 12'o3333, 12'o4444};
    xfer(0, -1, 0);
  endtask

  task automatic test_full;
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(12'(i));
    xfer(0, -1, 0);
    total++; if (mem[255] !== 12'd255 || mem[0] !== 12'd0) begin
      bad++; $display("FAIL full_mem m0=%0d m255=%0d exp 0,255", mem[0], mem[255]);
    end
  endtask

  task automatic test_stall;
    q = '{12'o0707, 12'o1234, 12'o7070};
    xfer(0, 1, 1);
  endtask

  task automatic test_abort;
    logic [11:0] w [3];
    foreach (w[i]) w[i] = 12'($urandom);
    mem[3] = 12'hABC;
    @(negedge clk); start = 1; abort = 1; len = 9'd8;
    @(negedge clk); start = 0; abort = 0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle busy=%b exp=0", busy); end
    start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 3; i++) begin src_valid = 1; src_data = w[i]; @(negedge clk); end
    src_data = 12'o5555; abort = 1; #1;
    total++; if (src_ready !== 1'b0 || buf_ce !== 1'b0) begin
      bad++; $display("FAIL abort_word rdy=%b ce=%b exp 0,0", src_ready, buf_ce);
    end
    @(negedge clk); abort = 0; src_valid = 0; #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy=%b done=%b exp 0,0", busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (mem[i] !== w[i]) begin bad++; $display("FAIL abort_mem%0d got=%o exp=%o", i, mem[i], w[i]); end
    end
    total++; if (mem[3] !== 12'hABC) begin bad++; $display("FAIL abort_mem3 got=%h exp=abc", mem[3]); end
    q = '{12'o1, 12'o2, 12'o3};
    xfer(0, -1, 0);
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk); start = 1; len = 9'd4;
    @(negedge clk); start = 0;
    for (int i = 0; i < 4; i++) begin src_valid = 1; src_data = 12'(i + 100); @(negedge clk); end
    src_valid = 0; snk_ready = 0; cyc = 0;
    #1; while (!snk_valid && cyc < 10) begin @(negedge clk); #1; cyc++; end
    total++; if (snk_valid !== 1'b1) begin bad++; $display("FAIL reach_out snk_valid=%b exp=1", snk_valid); end
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; #1;
    total++;
    if ({src_ready, snk_valid, buf_ce, buf_we, busy, done} !== 6'b0 || buf_a !== 8'd0 || buf_din !== 12'd0) begin
      bad++; $display("FAIL reset_mid ctl=%b a=%0d din=%o exp all 0", {src_ready, snk_valid, buf_ce, buf_we, busy, done}, buf_a, buf_din);
    end
    q = '{12'o7, 12'o77, 12'o777, 12'o7777};
    xfer(0, -1, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      q = {};
      for (int i = 0, n = $urandom_range(1, 40); i < n; i++) q.push_back(12'($urandom));
      xfer(1, -1, 0);
    end
  endtask

`ifdef RF_BUF_CKSUM_EN
  task automatic test_cksum;
    q = '{12'o7777, 12'o0001};
    xfer(0, -1, 0);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_stall;
    test_abort;
    test_reset_mid;
    test_random;
`ifdef RF_BUF_CKSUM_EN
    test_cksum;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
